// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronises and debounces four direction buttons and a function
//            button, producing one-cycle move strobes with hold-to-repeat and
//            a function-mode level toggled by each debounced press.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       East,
    input  logic       West,
    input  logic       North,
    input  logic       South,
    input  logic       func_switch,
    output logic       east_pulse,
    output logic       west_pulse,
    output logic       north_pulse,
    output logic       south_pulse,
    output logic [3:0] dir_held,
    output logic       func_mode
);

    // Channel order: 0=West, 1=East, 2=South, 3=North, 4=function.
    // Bits 3:0 therefore line up directly with dir_held {N,S,E,W}.
    localparam int c_NCH  = 5;
    localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RP_W = (c_RP_MAX > 1) ? $clog2(c_RP_MAX) : 1;

    localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RP_W-1:0] c_RP_DELAY  = c_RP_W'(REPEAT_DELAY - 1);
    localparam logic [c_RP_W-1:0] c_RP_RATE   = c_RP_W'(REPEAT_RATE - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DELAY  = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    logic [c_NCH-1:0] w_raw;
    logic [c_NCH-1:0] r_s1;
    logic [c_NCH-1:0] r_s2;
    logic [c_NCH-1:0] w_stable;
    logic [c_NCH-1:0] w_stable_nxt;
    logic [3:0]       w_pulse;
    logic             r_func_mode;

    assign w_raw = {func_switch, North, South, East, West};

    // Two-flop synchroniser for every raw pin.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < c_NCH; g++) begin : g_chan
        logic [c_DB_W-1:0] r_db_cnt;
        logic              r_stable;
        logic              w_flip;

        // The level flips only after the synchronised input has disagreed
        // with it for DEBOUNCE_CYCLES consecutive cycles.
        assign w_flip = (r_s2[g] != r_stable) && (r_db_cnt == c_DB_LAST);

        // Debounce counter and stable level.
        always_ff @(posedge sysclk or posedge rst) begin
            if (rst) begin
                r_db_cnt <= '0;
                r_stable <= 1'b0;
            end else if (r_s2[g] == r_stable) begin
                r_db_cnt <= '0;
            end else if (w_flip) begin
                r_db_cnt <= '0;
                r_stable <= r_s2[g];
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
        end

        assign w_stable[g]     = r_stable;
        assign w_stable_nxt[g] = w_flip ? r_s2[g] : r_stable;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dir
        logic [1:0]        r_state;
        logic [1:0]        w_state_nxt;
        logic [c_RP_W-1:0] r_rcnt;
        logic [c_RP_W-1:0] w_rcnt_nxt;
        logic              r_pulse;
        logic              w_pulse_nxt;

        // Repeat state, counter and registered move strobe.
        always_ff @(posedge sysclk or posedge rst) begin
            if (rst) begin
                r_state <= c_IDLE;
                r_rcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_rcnt  <= w_rcnt_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        // Next state works from the level the debouncer is about to
        // register, so a release suppresses a coincident repeat pulse.
        always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            w_pulse_nxt = 1'b0;
            if (!w_stable_nxt[g]) begin
                w_state_nxt = c_IDLE;
                w_rcnt_nxt  = '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (!w_stable[g]) begin
                            w_state_nxt = c_DELAY;
                            w_rcnt_nxt  = c_RP_DELAY;
                            w_pulse_nxt = 1'b1;
                        end
                    end
                    c_DELAY, c_REPEAT: begin
                        if (r_rcnt == '0) begin
                            w_state_nxt = c_REPEAT;
                            w_rcnt_nxt  = c_RP_RATE;
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_rcnt_nxt = r_rcnt - c_RP_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = c_IDLE;
                        w_rcnt_nxt  = '0;
                    end
                endcase
            end
        end

        assign w_pulse[g] = r_pulse;
    end

    // Function mode toggles on each debounced press; release is ignored.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_func_mode <= 1'b0;
        end else if (w_stable_nxt[4] && !w_stable[4]) begin
            r_func_mode <= ~r_func_mode;
        end
    end

    assign west_pulse  = w_pulse[0];
    assign east_pulse  = w_pulse[1];
    assign south_pulse = w_pulse[2];
    assign north_pulse = w_pulse[3];
    assign dir_held    = w_stable[3:0];
    assign func_mode   = r_func_mode;

endmodule
`default_nettype wire
